// File: rtl/sb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_bus_pkg
// Description : Shared types for the system-bus master arbiter: FSM state
//               encoding, owner constants, the per-master bus bundle and the
//               round-robin owner pick.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_bus_pkg;

    // Arbiter FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_GRANTED  = 2'd2,
        ST_ACTIVE   = 2'd3
    } sb_arb_state_t;

    // Owner identifiers: m0 is the JTAG debug master, m1 the secondary master
    localparam logic c_OWNER_M0 = 1'b0;
    localparam logic c_OWNER_M1 = 1'b1;

    // Everything one master drives onto the wired-OR system bus
    typedef struct packed {
        logic [31:0] address_data;
        logic [3:0]  byte_enables;
        logic [7:0]  burst_size;
        logic        read_n_write;
        logic        begin_transaction;
        logic        end_transaction;
        logic        data_valid;
    } sb_master_bus_t;

    // Single requester wins outright; on contention the master that did not
    // own the bus last time is picked.
    function automatic logic pick_owner(
        input logic req_m0,
        input logic req_m1,
        input logic last_owner
    );
        logic owner;
        if (req_m0 && req_m1) begin
            owner = ~last_owner;
        end else if (req_m1) begin
            owner = c_OWNER_M1;
        end else begin
            owner = c_OWNER_M0;
        end
        return owner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_master_mux.sv
`default_nettype none
// ============================================================================
// Module      : sb_master_mux
// Description : Owner-selected output mux. Drives the owning master's bus
//               bundle while enabled, otherwise all zeros so the wired-OR
//               system bus idles at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_master_mux
    import sb_bus_pkg::*;
(
    input  logic           enable,
    input  logic           owner,
    input  sb_master_bus_t m0_bus,
    input  sb_master_bus_t m1_bus,
    output sb_master_bus_t sb_bus
);

    // Select the owner's bundle, or zeros when no master holds the bus
    always_comb begin
        sb_bus = '0;
        if (enable) begin
            sb_bus = (owner == c_OWNER_M1) ? m1_bus : m0_bus;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sb_master_arbiter
// Description : Two-master front end for the system bus. Picks an owner
//               round-robin, requests the bus, passes the grant pulse back,
//               muxes the owner onto the bus and revokes the grant if the
//               owner never begins a transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_master_arbiter
    import sb_bus_pkg::*;
#(
    parameter int BEGIN_TIMEOUT = 64,
    parameter int TIMEOUT_W     = 8
) (
    input  logic        sb_clock_i,
    input  logic        sb_reset_n_i,

    input  logic        m0_request_i,
    output logic        m0_grant_o,
    input  logic [31:0] m0_address_data_i,
    input  logic [3:0]  m0_byte_enables_i,
    input  logic [7:0]  m0_burst_size_i,
    input  logic        m0_read_n_write_i,
    input  logic        m0_begin_transaction_i,
    input  logic        m0_end_transaction_i,
    input  logic        m0_data_valid_i,

    input  logic        m1_request_i,
    output logic        m1_grant_o,
    input  logic [31:0] m1_address_data_i,
    input  logic [3:0]  m1_byte_enables_i,
    input  logic [7:0]  m1_burst_size_i,
    input  logic        m1_read_n_write_i,
    input  logic        m1_begin_transaction_i,
    input  logic        m1_end_transaction_i,
    input  logic        m1_data_valid_i,

    output logic        sb_request_o,
    input  logic        sb_grant_i,
    output logic [31:0] sb_address_data_o,
    output logic [3:0]  sb_byte_enables_o,
    output logic [7:0]  sb_burst_size_o,
    output logic        sb_read_n_write_o,
    output logic        sb_begin_transaction_o,
    output logic        sb_end_transaction_o,
    output logic        sb_data_valid_o,
    input  logic        sb_end_transaction_i,
    input  logic        sb_error_i,
    output logic        timeout_o
);

    localparam logic [TIMEOUT_W-1:0] c_TIMEOUT_MAX = TIMEOUT_W'(BEGIN_TIMEOUT);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;

    sb_arb_state_t        r_state;
    sb_arb_state_t        w_state_next;
    logic                 r_owner;
    logic                 w_owner_next;
    logic                 r_last_owner;
    logic                 w_last_owner_next;
    logic [TIMEOUT_W-1:0] r_count;
    logic [TIMEOUT_W-1:0] w_count_next;
    logic [TIMEOUT_W-1:0] w_count_inc;
    logic                 r_sb_request;
    logic                 r_timeout;
    logic                 w_timeout_next;

    logic                 w_owner_req;
    logic                 w_owner_begin;
    logic                 w_owner_end;
    logic                 w_bus_enable;

    sb_master_bus_t       w_m0_bus;
    sb_master_bus_t       w_m1_bus;
    sb_master_bus_t       w_sb_bus;

    // Reset asserts immediately but releases only on a clock edge
    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Handshake inputs of whichever master currently owns the arbiter
    assign w_owner_req   = (r_owner == c_OWNER_M1) ? m1_request_i           : m0_request_i;
    assign w_owner_begin = (r_owner == c_OWNER_M1) ? m1_begin_transaction_i : m0_begin_transaction_i;
    assign w_owner_end   = (r_owner == c_OWNER_M1) ? m1_end_transaction_i   : m0_end_transaction_i;

    // Counter never wraps: it parks at the timeout value
    assign w_count_inc = (r_count == c_TIMEOUT_MAX) ? r_count : r_count + 1'b1;

    // Next-state, owner bookkeeping and timeout detection
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_count_next      = r_count;
        w_timeout_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_request_i || m1_request_i) begin
                    w_owner_next = pick_owner(m0_request_i, m1_request_i, r_last_owner);
                    w_state_next = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // A grant arriving in the same cycle as the drop still wins
                if (sb_grant_i) begin
                    w_state_next = ST_GRANTED;
                    w_count_next = '0;
                end else if (!w_owner_req) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                w_count_next = w_count_inc;
                if (w_owner_begin && w_owner_end) begin
                    w_state_next      = ST_IDLE;
                    w_last_owner_next = r_owner;
                end else if (w_owner_begin) begin
                    w_state_next = ST_ACTIVE;
                end else if (w_count_inc == c_TIMEOUT_MAX) begin
                    w_state_next      = ST_IDLE;
                    w_timeout_next    = 1'b1;
                    w_last_owner_next = r_owner;
                end
            end
            ST_ACTIVE: begin
                if (sb_end_transaction_i || w_owner_end || sb_error_i) begin
                    w_state_next      = ST_IDLE;
                    w_last_owner_next = r_owner;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Arbiter state register; last_owner resets to m1 so m0 wins first contention
    always_ff @(posedge sb_clock_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= c_OWNER_M0;
            r_last_owner <= c_OWNER_M1;
            r_count      <= '0;
            r_sb_request <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_count      <= w_count_next;
            r_sb_request <= (w_state_next == ST_REQUEST);
            r_timeout    <= w_timeout_next;
        end
    end

    assign sb_request_o = r_sb_request;
    assign timeout_o    = r_timeout;

    // Grant is passed straight through to the owner only
    assign m0_grant_o = sb_grant_i && (r_state == ST_REQUEST) && (r_owner == c_OWNER_M0);
    assign m1_grant_o = sb_grant_i && (r_state == ST_REQUEST) && (r_owner == c_OWNER_M1);

    assign w_bus_enable = (r_state == ST_GRANTED) || (r_state == ST_ACTIVE);

    assign w_m0_bus = '{
        address_data:      m0_address_data_i,
        byte_enables:      m0_byte_enables_i,
        burst_size:        m0_burst_size_i,
        read_n_write:      m0_read_n_write_i,
        begin_transaction: m0_begin_transaction_i,
        end_transaction:   m0_end_transaction_i,
        data_valid:        m0_data_valid_i
    };

    assign w_m1_bus = '{
        address_data:      m1_address_data_i,
        byte_enables:      m1_byte_enables_i,
        burst_size:        m1_burst_size_i,
        read_n_write:      m1_read_n_write_i,
        begin_transaction: m1_begin_transaction_i,
        end_transaction:   m1_end_transaction_i,
        data_valid:        m1_data_valid_i
    };

    sb_master_mux u_master_mux (
        .enable (w_bus_enable),
        .owner  (r_owner),
        .m0_bus (w_m0_bus),
        .m1_bus (w_m1_bus),
        .sb_bus (w_sb_bus)
    );

    assign sb_address_data_o      = w_sb_bus.address_data;
    assign sb_byte_enables_o      = w_sb_bus.byte_enables;
    assign sb_burst_size_o        = w_sb_bus.burst_size;
    assign sb_read_n_write_o      = w_sb_bus.read_n_write;
    assign sb_begin_transaction_o = w_sb_bus.begin_transaction;
    assign sb_end_transaction_o   = w_sb_bus.end_transaction;
    assign sb_data_valid_o        = w_sb_bus.data_valid;

endmodule
`default_nettype wire

// File: tb/tb_sb_master_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sb_master_arbiter
// Description : Directed self-checking bench for sb_master_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_master_arbiter;

    logic        sb_clock_i = 1'b0;
    logic        sb_reset_n_i;
    logic        m0_request_i, m0_grant_o;
    logic [31:0] m0_address_data_i;
    logic [3:0]  m0_byte_enables_i;
    logic [7:0]  m0_burst_size_i;
    logic        m0_read_n_write_i, m0_begin_transaction_i, m0_end_transaction_i, m0_data_valid_i;
    logic        m1_request_i, m1_grant_o;
    logic [31:0] m1_address_data_i;
    logic [3:0]  m1_byte_enables_i;
    logic [7:0]  m1_burst_size_i;
    logic        m1_read_n_write_i, m1_begin_transaction_i, m1_end_transaction_i, m1_data_valid_i;
    logic        sb_request_o, sb_grant_i;
    logic [31:0] sb_address_data_o;
    logic [3:0]  sb_byte_enables_o;
    logic [7:0]  sb_burst_size_o;
    logic        sb_read_n_write_o, sb_begin_transaction_o, sb_end_transaction_o, sb_data_valid_o;
    logic        sb_end_transaction_i, sb_error_i, timeout_o;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    sb_master_arbiter #(.BEGIN_TIMEOUT(64), .TIMEOUT_W(8)) dut (
        .sb_clock_i             (sb_clock_i),
        .sb_reset_n_i           (sb_reset_n_i),
        .m0_request_i           (m0_request_i),
        .m0_grant_o             (m0_grant_o),
        .m0_address_data_i      (m0_address_data_i),
        .m0_byte_enables_i      (m0_byte_enables_i),
        .m0_burst_size_i        (m0_burst_size_i),
        .m0_read_n_write_i      (m0_read_n_write_i),
        .m0_begin_transaction_i (m0_begin_transaction_i),
        .m0_end_transaction_i   (m0_end_transaction_i),
        .m0_data_valid_i        (m0_data_valid_i),
        .m1_request_i           (m1_request_i),
        .m1_grant_o             (m1_grant_o),
        .m1_address_data_i      (m1_address_data_i),
        .m1_byte_enables_i      (m1_byte_enables_i),
        .m1_burst_size_i        (m1_burst_size_i),
        .m1_read_n_write_i      (m1_read_n_write_i),
        .m1_begin_transaction_i (m1_begin_transaction_i),
        .m1_end_transaction_i   (m1_end_transaction_i),
        .m1_data_valid_i        (m1_data_valid_i),
        .sb_request_o           (sb_request_o),
        .sb_grant_i             (sb_grant_i),
        .sb_address_data_o      (sb_address_data_o),
        .sb_byte_enables_o      (sb_byte_enables_o),
        .sb_burst_size_o        (sb_burst_size_o),
        .sb_read_n_write_o      (sb_read_n_write_o),
        .sb_begin_transaction_o (sb_begin_transaction_o),
        .sb_end_transaction_o   (sb_end_transaction_o),
        .sb_data_valid_o        (sb_data_valid_o),
        .sb_end_transaction_i   (sb_end_transaction_i),
        .sb_error_i             (sb_error_i),
        .timeout_o              (timeout_o)
    );

    always #5 sb_clock_i = ~sb_clock_i;

    // Count every comparison and report any mismatch
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge sb_clock_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_request_i = 0; m0_address_data_i = '0; m0_byte_enables_i = '0; m0_burst_size_i = '0;
        m0_read_n_write_i = 0; m0_begin_transaction_i = 0; m0_end_transaction_i = 0; m0_data_valid_i = 0;
        m1_request_i = 0; m1_address_data_i = '0; m1_byte_enables_i = '0; m1_burst_size_i = '0;
        m1_read_n_write_i = 0; m1_begin_transaction_i = 0; m1_end_transaction_i = 0; m1_data_valid_i = 0;
        sb_grant_i = 0; sb_end_transaction_i = 0; sb_error_i = 0;
    endtask

    // Hard stop if the directed sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        clear_inputs();
        sb_reset_n_i = 0;
        sb_grant_i   = 1;
        step(); step();
        #1;
        check_val("rst_request", sb_request_o, 0);
        check_val("rst_timeout", timeout_o, 0);
        check_val("rst_m0_grant", m0_grant_o, 0);
        check_val("rst_m1_grant", m1_grant_o, 0);
        check_val("rst_addr", sb_address_data_o, 0);
        sb_grant_i   = 0;
        sb_reset_n_i = 1;
        repeat (3) step();

        // ---------------- both request out of reset: m0 then m1 ----------------
        m0_request_i = 1; m1_request_i = 1;
        m0_address_data_i = 32'h0000_00A0; m1_address_data_i = 32'h0000_00B1;
        step();
        #1;
        check_val("s2_req_hi", sb_request_o, 1);
        sb_grant_i = 1; #1;
        check_val("s2_m0_grant", m0_grant_o, 1);
        check_val("s2_m1_grant", m1_grant_o, 0);
        step();
        sb_grant_i = 0; m0_begin_transaction_i = 1; #1;
        check_val("s2_granted_addr", sb_address_data_o, 32'h0000_00A0);
        check_val("s2_granted_begin", sb_begin_transaction_o, 1);
        check_val("s2_granted_req_lo", sb_request_o, 0);
        step();
        m0_begin_transaction_i = 0; sb_end_transaction_i = 1; #1;
        check_val("s2_active_addr", sb_address_data_o, 32'h0000_00A0);
        step();
        sb_end_transaction_i = 0; #1;
        check_val("s2_idle_addr", sb_address_data_o, 0);
        check_val("s2_idle_req", sb_request_o, 0);
        step();
        sb_grant_i = 1; #1;
        check_val("s2_rr_req", sb_request_o, 1);
        check_val("s2_rr_m1_grant", m1_grant_o, 1);
        check_val("s2_rr_m0_grant", m0_grant_o, 0);
        step();
        sb_grant_i = 0; m0_request_i = 0; m1_request_i = 0;
        m1_begin_transaction_i = 1; m1_end_transaction_i = 1; m1_byte_enables_i = 4'hF; #1;
        check_val("s2_m1_addr", sb_address_data_o, 32'h0000_00B1);
        check_val("s2_m1_end", sb_end_transaction_o, 1);
        step();
        m1_begin_transaction_i = 0; m1_end_transaction_i = 0; #1;
        check_val("s2_begin_end_idle_be", sb_byte_enables_o, 0);
        check_val("s2_begin_end_idle_addr", sb_address_data_o, 0);
        clear_inputs();
        step();

        // ---------------- m0 alone, grant after 3 request cycles ----------------
        m0_request_i = 1; #1;
        check_val("s1_req_before", sb_request_o, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) sb_grant_i = 1;
            #1;
            check_val($sformatf("s1_req_c%0d", i), sb_request_o, 1);
            check_val($sformatf("s1_m0_grant_c%0d", i), m0_grant_o, (i == 2) ? 1 : 0);
            check_val($sformatf("s1_m1_grant_c%0d", i), m1_grant_o, 0);
        end
        step();
        sb_grant_i = 0; m0_request_i = 0; #1;
        check_val("s1_req_lo", sb_request_o, 0);
        check_val("s1_m0_grant_lo", m0_grant_o, 0);
        m0_begin_transaction_i = 1;
        step();
        m0_begin_transaction_i = 0; m0_end_transaction_i = 1; #1;
        check_val("s1_end_out", sb_end_transaction_o, 1);
        step();
        m0_end_transaction_i = 0; #1;
        check_val("s1_idle_end", sb_end_transaction_o, 0);
        clear_inputs();
        step();

        // ---------------- m1 write burst of 4 at 0x1000, m0 noise ignored ----------------
        m0_address_data_i = 32'hDEAD_BEEF; m0_byte_enables_i = 4'hF; m0_burst_size_i = 8'h55;
        m0_read_n_write_i = 1; m0_begin_transaction_i = 1; m0_end_transaction_i = 1; m0_data_valid_i = 1;
        m1_request_i = 1;
        step();
        sb_grant_i = 1; #1;
        check_val("s3_m1_grant", m1_grant_o, 1);
        check_val("s3_m0_grant", m0_grant_o, 0);
        step();
        sb_grant_i = 0; m1_request_i = 0;
        m1_address_data_i = 32'h0000_1000; m1_byte_enables_i = 4'hF; m1_burst_size_i = 8'd4;
        m1_read_n_write_i = 0; m1_begin_transaction_i = 1; #1;
        check_val("s3_addr", sb_address_data_o, 32'h0000_1000);
        check_val("s3_burst", sb_burst_size_o, 8'd4);
        check_val("s3_rnw", sb_read_n_write_o, 0);
        check_val("s3_be", sb_byte_enables_o, 4'hF);
        check_val("s3_begin", sb_begin_transaction_o, 1);
        step();
        m1_begin_transaction_i = 0;
        for (int k = 0; k < 4; k++) begin
            m1_address_data_i    = 32'hA5A5_0000 + 32'(k);
            m1_data_valid_i      = 1;
            m1_end_transaction_i = (k == 3);
            #1;
            check_val($sformatf("s3_data_%0d", k), sb_address_data_o, 32'hA5A5_0000 + 32'(k));
            check_val($sformatf("s3_dv_%0d", k), sb_data_valid_o, 1);
            step();
        end
        #1;
        check_val("s3_idle_addr", sb_address_data_o, 0);
        check_val("s3_idle_dv", sb_data_valid_o, 0);
        check_val("s3_idle_begin", sb_begin_transaction_o, 0);
        clear_inputs();
        step();

        // ---------------- grant, owner never begins: timeout ----------------
        m0_request_i = 1;
        step();
        sb_grant_i = 1;
        step();
        sb_grant_i = 0; m0_request_i = 0; m0_byte_enables_i = 4'h3; #1;
        check_val("s4_granted_be", sb_byte_enables_o, 4'h3);
        check_val("s4_no_timeout_yet", timeout_o, 0);
        cnt = 0;
        while (timeout_o !== 1'b1 && cnt < 200) begin
            step();
            cnt++;
        end
        check_val("s4_timeout_cycles", cnt, 64);
        #1;
        check_val("s4_idle_be", sb_byte_enables_o, 0);
        check_val("s4_idle_req", sb_request_o, 0);
        step();
        check_val("s4_timeout_pulse", timeout_o, 0);
        clear_inputs();
        step();

        // ---------------- error in ACTIVE, other requester served next ----------------
        m0_request_i = 1; m1_request_i = 1; m1_address_data_i = 32'h0000_0011;
        step();
        sb_grant_i = 1; #1;
        check_val("s5_m1_grant", m1_grant_o, 1);
        check_val("s5_m0_grant", m0_grant_o, 0);
        step();
        sb_grant_i = 0; m1_begin_transaction_i = 1;
        step();
        m1_begin_transaction_i = 0; sb_error_i = 1; #1;
        check_val("s5_active_addr", sb_address_data_o, 32'h0000_0011);
        step();
        sb_error_i = 0; #1;
        check_val("s5_err_idle_addr", sb_address_data_o, 0);
        check_val("s5_err_idle_req", sb_request_o, 0);
        step();
        sb_grant_i = 1; #1;
        check_val("s5_next_m0_grant", m0_grant_o, 1);
        check_val("s5_next_m1_grant", m1_grant_o, 0);
        step();
        sb_grant_i = 0; m0_request_i = 0; m1_request_i = 0;
        m0_begin_transaction_i = 1; m0_end_transaction_i = 1;
        step();
        clear_inputs();
        step();

        // ---------------- reset pulse in ACTIVE, m0 favoured afterwards ----------------
        m0_request_i = 1; m1_request_i = 1;
        m0_address_data_i = 32'h0000_0077; m1_address_data_i = 32'h0000_0066;
        m1_byte_enables_i = 4'hC;
        step();
        sb_grant_i = 1; #1;
        check_val("s6_m1_grant", m1_grant_o, 1);
        step();
        sb_grant_i = 0; m1_begin_transaction_i = 1;
        step();
        m1_begin_transaction_i = 0; #1;
        check_val("s6_active_addr", sb_address_data_o, 32'h0000_0066);
        sb_grant_i = 1;
        sb_reset_n_i = 0; #1;
        check_val("s6_rst_addr", sb_address_data_o, 0);
        check_val("s6_rst_be", sb_byte_enables_o, 0);
        check_val("s6_rst_m0_grant", m0_grant_o, 0);
        check_val("s6_rst_m1_grant", m1_grant_o, 0);
        check_val("s6_rst_req", sb_request_o, 0);
        check_val("s6_rst_timeout", timeout_o, 0);
        step(); step();
        sb_grant_i = 0;
        sb_reset_n_i = 1;
        cnt = 0;
        while (sb_request_o !== 1'b1 && cnt < 10) begin
            step();
            cnt++;
        end
        check_val("s6_rerequest_seen", sb_request_o, 1);
        sb_grant_i = 1; #1;
        check_val("s6_after_rst_m0_grant", m0_grant_o, 1);
        check_val("s6_after_rst_m1_grant", m1_grant_o, 0);
        step();
        sb_grant_i = 0; m0_request_i = 0; m1_request_i = 0;
        m0_begin_transaction_i = 1; m0_end_transaction_i = 1;
        step();
        clear_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
